addsub_pipe: RTL and testbench

- Parametrised, pipelined signed/unsigned adder-subtractor; successor to the team's 4-bit combinational adder_sub.
- Adds generic WIDTH, configurable pipeline depth and valid/ready handshakes on both sides.
- Adds signed-overflow and zero flags, plus optional saturation.
- Sits between operand-producing blocks and downstream ALU/accumulator logic.

---
 rtl/addsub_pipe.sv | 124 ++++++++++++
 tb/tb_addsub_pipe.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_pipe.sv
// addsub_pipe: pipelined adder-subtractor with valid/ready handshakes on both sides.
// Stage 1 computes result, raw carry, signed overflow and zero from the accepted
// operands; later stages only delay that record. Bubbles collapse toward the
// output so a stalled pipeline is always packed.
// Optional feature macro ADDSUB_SAT_EN: signed saturation of the result in stage 1.
module addsub_pipe #(
  parameter int WIDTH       = 8,
  parameter int PIPE_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             carry_in,
  input  logic             control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  // Per-stage record layout: {result, carry_out, overflow, zero}
  localparam int RW = WIDTH + 3;

  logic [WIDTH-1:0]       b_eff;
  logic [WIDTH:0]         sum_full;
  logic [WIDTH-1:0]       raw;
  logic [WIDTH-1:0]       res;
  logic                   ovf_s1;
  logic                   zero_s1;
  logic [RW-1:0]          s1_rec;

  logic [PIPE_STAGES-1:0] valid_q;
  logic [PIPE_STAGES-1:0] valid_d;
  logic [PIPE_STAGES-1:0] load;
  logic                   chain;
  logic [RW-1:0]          data_q [PIPE_STAGES];
  logic [RW-1:0]          data_d [PIPE_STAGES];

  // Stage-1 arithmetic: carry_in is never forced by control, so a true A-B needs carry_in=1.
  always_comb begin
    b_eff    = in2 ^ {WIDTH{control}};
    sum_full = {1'b0, in1} + {1'b0, b_eff} + {{WIDTH{1'b0}}, carry_in};
    raw      = sum_full[WIDTH-1:0];
    ovf_s1   = (in1[WIDTH-1] == b_eff[WIDTH-1]) && (raw[WIDTH-1] != in1[WIDTH-1]);
`ifdef ADDSUB_SAT_EN
    if (ovf_s1) begin
      res = in1[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      res = raw;
    end
`else
    res = raw;
`endif
    zero_s1 = (res == '0);
    s1_rec  = {res, sum_full[WIDTH], ovf_s1, zero_s1};
  end

  // Load enables, walked from the output back: a stage loads if it is empty or its content moves on.
  always_comb begin
    load  = '0;
    chain = out_ready;
    for (int k = PIPE_STAGES - 1; k >= 0; k--) begin
      chain   = !valid_q[k] || chain;
      load[k] = chain;
    end
  end

  // Input handshake: independent of in_valid, held low while in reset.
  always_comb begin
    in_ready = rst_n && load[0];
  end

  // Next-state for valid bits and stage records.
  always_comb begin
    valid_d = valid_q;
    for (int k = 0; k < PIPE_STAGES; k++) begin
      data_d[k] = data_q[k];
    end
    if (load[0]) begin
      valid_d[0] = in_valid;
      if (in_valid) begin
        data_d[0] = s1_rec;
      end
    end
    for (int k = 1; k < PIPE_STAGES; k++) begin
      if (load[k]) begin
        valid_d[k] = valid_q[k-1];
        data_d[k]  = data_q[k-1];
      end
    end
  end

  // Valid bits: only these are reset, so in-flight items vanish immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Stage data registers: no reset, qualified by the valid bits.
  always_ff @(posedge clk) begin
    for (int k = 0; k < PIPE_STAGES; k++) begin
      data_q[k] <= data_d[k];
    end
  end

  // Outputs gated by the last valid bit so they read 0 when empty or in reset.
  always_comb begin
    out_valid = valid_q[PIPE_STAGES-1];
    if (out_valid) begin
      {out, carry_out, overflow, zero} = data_q[PIPE_STAGES-1];
    end else begin
      {out, carry_out, overflow, zero} = '0;
    end
  end

endmodule

// File: tb/tb_addsub_pipe.sv
// Self-checking bench for addsub_pipe (WIDTH=4, PIPE_STAGES=2).
// Reference: arithmetic model of each accepted item plus a queue-based timing model.
module tb_addsub_pipe;

  localparam int W    = 4;
  localparam int S    = 2;
  localparam int MASK = (1 << W) - 1;
  localparam int HALF = 1 << (W - 1);
`ifdef ADDSUB_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in1;
  logic [W-1:0] in2;
  logic         carry_in;
  logic         control;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out;
  logic         carry_out;
  logic         overflow;
  logic         zero;

  addsub_pipe #(.WIDTH(W), .PIPE_STAGES(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in1       (in1),
    .in2       (in2),
    .carry_in  (carry_in),
    .control   (control),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .carry_out (carry_out),
    .overflow  (overflow),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic         c;
    logic         v;
    logic         z;
    int           acc;
  } ent_t;

  ent_t q[$];
  int   total;
  int   bad;
  int   cyc;
  int   last_dep;
  int   ready_at;
  bit   ev;
  ent_t e_new;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Plain-integer reference: signed overflow means the true signed sum is out of range.
  function automatic ent_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic ctl, input logic cin);
    ent_t r;
    int ua, ube, s, sa, sb, ss, rv;
    ua  = int'(a);
    ube = ctl ? ((~int'(b)) & MASK) : int'(b);
    s   = ua + ube + int'(cin);
    sa  = (ua >= HALF) ? ua - (1 << W) : ua;
    sb  = (ube >= HALF) ? ube - (1 << W) : ube;
    ss  = sa + sb + int'(cin);
    r.c = ((s >> W) & 1) != 0;
    r.v = (ss > HALF - 1) || (ss < -HALF);
    rv  = s & MASK;
    if (SAT && r.v) rv = (ss > 0) ? HALF - 1 : HALF;
    r.res = rv[W-1:0];
    r.z   = (rv == 0);
    r.acc = 0;
    return r;
  endfunction

  // Compare process: every falling edge, against the model queue.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      last_dep = -100;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_outputs", {25'd0, out, carry_out, overflow, zero}, 32'd0);
    end else begin
      ev = 1'b0;
      if (q.size() > 0) begin
        ready_at = q[0].acc + S;
        if (last_dep + 1 > ready_at) ready_at = last_dep + 1;
        ev = (cyc >= ready_at);
      end
      chk("out_valid", {31'd0, out_valid}, {31'd0, ev});
      chk("in_ready", {31'd0, in_ready}, {31'd0, (q.size() < S) || out_ready});
      if (ev && out_valid) begin
        chk("result", {25'd0, out, carry_out, overflow, zero},
            {25'd0, q[0].res, q[0].c, q[0].v, q[0].z});
      end else if (!out_valid) begin
        chk("idle_outputs", {25'd0, out, carry_out, overflow, zero}, 32'd0);
      end
      if (ev && out_ready) begin
        void'(q.pop_front());
        last_dep = cyc;
      end
      if (in_valid && in_ready) begin
        e_new     = model(in1, in2, control, carry_in);
        e_new.acc = cyc;
        q.push_back(e_new);
      end
    end
    cyc++;
  end

  task automatic new_ops();
    in1      = W'($urandom);
    in2      = W'($urandom);
    control  = 1'($urandom);
    carry_in = 1'($urandom);
  endtask

  // One item into an empty pipeline; result must appear exactly S cycles later.
  task automatic send_check(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic ctl, input logic cin, input logic [W-1:0] eo,
                            input logic ec, input logic ev_l, input logic ez);
    ent_t m;
    m = model(a, b, ctl, cin);
    chk({name, "_model_pin"}, {25'd0, m.res, m.c, m.v, m.z}, {25'd0, eo, ec, ev_l, ez});
    in1 = a; in2 = b; control = ctl; carry_in = cin;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({name, "_lat1"}, {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    chk({name, "_lat2"}, {31'd0, out_valid}, 32'd1);
    chk({name, "_lit"}, {25'd0, out, carry_out, overflow, zero}, {25'd0, eo, ec, ev_l, ez});
  endtask

  task automatic run(input int n, input int stall, input int vp, input int rp, input int maxc);
    int sent;
    int c;
    bit acc;
    sent = 0;
    c = 0;
    new_ops();
    while ((sent < n || q.size() > 0) && c < maxc) begin
      in_valid  = (sent < n) && ($urandom_range(99) < vp);
      out_ready = (c < stall) ? 1'b0 : ($urandom_range(99) < rp);
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) begin
        sent++;
        new_ops();
      end
      c++;
    end
    in_valid = 1'b0;
    chk("run_completed", {31'd0, c < maxc}, 32'd1);
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0; last_dep = -100;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in1 = '0; in2 = '0; carry_in = 1'b0; control = 1'b0;
    #1;
    chk("init_out_valid", {31'd0, out_valid}, 32'd0);
    chk("init_in_ready", {31'd0, in_ready}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    send_check("sub7m3", 4'b0111, 4'b0011, 1'b1, 1'b1, 4'b0100, 1'b1, 1'b0, 1'b0);
    send_check("add7p3", 4'b0111, 4'b0011, 1'b0, 1'b0, SAT ? 4'b0111 : 4'b1010, 1'b0, 1'b1, 1'b0);
    send_check("sub5m5", 4'b0101, 4'b0101, 1'b1, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b1);
    send_check("subm8m1", 4'b1000, 4'b0001, 1'b1, 1'b1, SAT ? 4'b1000 : 4'b0111, 1'b1, 1'b1, 1'b0);

    run(6, 4, 100, 100, 200);
    run(10, 0, 100, 100, 200);
    run(60, 0, 70, 70, 1000);
    run(60, 3, 50, 30, 2000);

    // Reset with two items in flight.
    out_ready = 1'b0;
    new_ops();
    in_valid = 1'b1;
    @(posedge clk); #1;
    new_ops();
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("pre_reset_full", {31'd0, out_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("reset_out_valid_now", {31'd0, out_valid}, 32'd0);
    chk("reset_in_ready_now", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("post_reset_in_ready", {31'd0, in_ready}, 32'd1);
    send_check("post_reset", 4'b0111, 4'b0011, 1'b1, 1'b1, 4'b0100, 1'b1, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("drained", q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
